// File: rtl/stepmotor_ctrl.sv
// Step-motor controller: accepts move commands and drives the four windings one step every DIV clk1h cycles.
// Define STEPMOTOR_HALF_STEP_EN for the 8-entry half-step sequence; the default build uses full steps.
module stepmotor_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV   = 1
) (
    input  logic             clk1h,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos,
    output logic [3:0]       phase
);

`ifdef STEPMOTOR_HALF_STEP_EN
    localparam int IDX_W = 3;

    function automatic logic [3:0] phase_lut(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    phase_lut = 4'b0101;
            3'd1:    phase_lut = 4'b0001;
            3'd2:    phase_lut = 4'b1001;
            3'd3:    phase_lut = 4'b1000;
            3'd4:    phase_lut = 4'b1010;
            3'd5:    phase_lut = 4'b0010;
            3'd6:    phase_lut = 4'b0110;
            3'd7:    phase_lut = 4'b0100;
            default: phase_lut = 4'b0101;
        endcase
    endfunction
`else
    localparam int IDX_W = 2;

    function automatic logic [3:0] phase_lut(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    phase_lut = 4'b0101;
            2'd1:    phase_lut = 4'b1001;
            2'd2:    phase_lut = 4'b1010;
            2'd3:    phase_lut = 4'b0110;
            default: phase_lut = 4'b0101;
        endcase
    endfunction
`endif

    localparam logic [7:0]       DIV_M1  = 8'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZER = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             dir_r;
    logic [CNT_W-1:0] remaining_r;
    logic [7:0]       div_cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [CNT_W-1:0] pos_nxt_s;
    logic             accept_s;
    logic             step_s;
    logic             ready_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    // Handshake and step-fire qualifiers; abort suppresses a step that was due on the same edge.
    always_comb begin
        accept_s  = cmd_ready & cmd_valid;
        step_s    = (state_r == S_RUN) && !abort && (div_cnt_r == DIV_M1);
        idx_nxt_s = dir_r ? (idx_r + IDX_ONE) : (idx_r - IDX_ONE);
        pos_nxt_s = dir_r ? (pos + CNT_ONE) : (pos - CNT_ONE);
    end

    // State register.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    next_state_s = (cmd_steps == CNT_ZER) ? S_DONE : S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    next_state_s = S_DONE;
                end else if (step_s && (remaining_r == CNT_ONE)) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so the registered copies track state_r.
    always_comb begin
        ready_nxt_s = (next_state_s == S_IDLE);
        busy_nxt_s  = (next_state_s == S_RUN);
        done_nxt_s  = (next_state_s == S_DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= ready_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
        end
    end

    // Move datapath: command latch, step divider, phase index and absolute position.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            dir_r       <= 1'b0;
            remaining_r <= CNT_ZER;
            div_cnt_r   <= 8'd0;
            idx_r       <= {IDX_W{1'b0}};
            phase       <= 4'b0101;
            pos         <= CNT_ZER;
        end else if (accept_s) begin
            dir_r       <= cmd_dir;
            remaining_r <= cmd_steps;
            div_cnt_r   <= 8'd0;
        end else if (step_s) begin
            div_cnt_r   <= 8'd0;
            remaining_r <= remaining_r - CNT_ONE;
            idx_r       <= idx_nxt_s;
            phase       <= phase_lut(idx_nxt_s);
            pos         <= pos_nxt_s;
        end else if ((state_r == S_RUN) && !abort) begin
            div_cnt_r   <= div_cnt_r + 8'd1;
        end else begin
            div_cnt_r   <= div_cnt_r;
        end
    end

endmodule

// File: tb/tb_stepmotor_ctrl.sv
// Self-checking bench for stepmotor_ctrl: two instances (DIV=2 and DIV=1) checked each cycle against a
// reference that derives step times, phase and position directly from the command.
module tb_stepmotor_ctrl;
    localparam int CNT_W = 16;
    localparam int DIV0  = 2;
    localparam int DIV1  = 1;
`ifdef STEPMOTOR_HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic              clk1h = 1'b0;
    logic              rst;
    logic              cmd_valid [2];
    logic              cmd_dir   [2];
    logic [CNT_W-1:0]  cmd_steps [2];
    logic              abort     [2];
    logic              cmd_ready [2];
    logic              busy      [2];
    logic              done      [2];
    logic [CNT_W-1:0]  pos       [2];
    logic [3:0]        phase     [2];

    int errors = 0;
    int checks = 0;
    int m_idx [2];
    int m_pos [2];

    always #5 clk1h = ~clk1h;

    stepmotor_ctrl #(.CNT_W(CNT_W), .DIV(DIV0)) u_dut0 (
        .clk1h(clk1h), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_dir(cmd_dir[0]), .cmd_steps(cmd_steps[0]), .abort(abort[0]), .busy(busy[0]),
        .done(done[0]), .pos(pos[0]), .phase(phase[0])
    );

    stepmotor_ctrl #(.CNT_W(CNT_W), .DIV(DIV1)) u_dut1 (
        .clk1h(clk1h), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_dir(cmd_dir[1]), .cmd_steps(cmd_steps[1]), .abort(abort[1]), .busy(busy[1]),
        .done(done[1]), .pos(pos[1]), .phase(phase[1])
    );

    function automatic logic [3:0] exp_phase(input int i);
        int n;
        n = ((i % NPH) + NPH) % NPH;
`ifdef STEPMOTOR_HALF_STEP_EN
        case (n)
            0: exp_phase = 4'b0101;  1: exp_phase = 4'b0001;
            2: exp_phase = 4'b1001;  3: exp_phase = 4'b1000;
            4: exp_phase = 4'b1010;  5: exp_phase = 4'b0010;
            6: exp_phase = 4'b0110;  default: exp_phase = 4'b0100;
        endcase
`else
        case (n)
            0: exp_phase = 4'b0101;  1: exp_phase = 4'b1001;
            2: exp_phase = 4'b1010;  default: exp_phase = 4'b0110;
        endcase
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input int u, input string tag, input logic r, input logic b,
                               input logic d, input logic [CNT_W-1:0] p, input logic [3:0] ph);
        chk($sformatf("u%0d %s cmd_ready", u, tag), {31'd0, cmd_ready[u]}, {31'd0, r});
        chk($sformatf("u%0d %s busy", u, tag), {31'd0, busy[u]}, {31'd0, b});
        chk($sformatf("u%0d %s done", u, tag), {31'd0, done[u]}, {31'd0, d});
        chk($sformatf("u%0d %s pos", u, tag), {16'd0, pos[u]}, {16'd0, p});
        chk($sformatf("u%0d %s phase", u, tag), {28'd0, phase[u]}, {28'd0, ph});
    endtask

    // Issue one command and check every cycle until the IDLE cycle after done.
    // abort_at >= 0: abort is raised on the edge where step abort_at+1 would fire.
    // hold: cmd_valid stays high throughout with scrambled command fields.
    task automatic run_move(input int u, input bit dir, input int steps, input int abort_at, input bit hold);
        int dv, taken, end_e, k, sgn;
        dv    = (u == 0) ? DIV0 : DIV1;
        sgn   = dir ? 1 : -1;
        taken = (abort_at >= 0) ? abort_at : steps;
        end_e = (steps == 0) ? 0 : ((abort_at >= 0) ? (abort_at + 1) * dv : steps * dv);
        chk($sformatf("u%0d pre-accept cmd_ready", u), {31'd0, cmd_ready[u]}, 32'd1);
        cmd_valid[u] = 1'b1;
        cmd_dir[u]   = dir;
        cmd_steps[u] = 16'(steps);
        for (int c = 0; c <= end_e + 1; c++) begin
            @(posedge clk1h);
            @(negedge clk1h);
            if (hold) begin
                cmd_steps[u] = 16'($urandom_range(1, 50));
                cmd_dir[u]   = 1'($urandom);
            end else begin
                cmd_valid[u] = 1'b0;
            end
            k = c / dv;
            if (k > taken) k = taken;
            if (c < end_e)
                expect_outs(u, "run", 1'b0, 1'b1, 1'b0, 16'(m_pos[u] + sgn * k), exp_phase(m_idx[u] + sgn * k));
            else if (c == end_e)
                expect_outs(u, "done", 1'b0, 1'b0, 1'b1, 16'(m_pos[u] + sgn * k), exp_phase(m_idx[u] + sgn * k));
            else
                expect_outs(u, "idle", 1'b1, 1'b0, 1'b0, 16'(m_pos[u] + sgn * k), exp_phase(m_idx[u] + sgn * k));
            abort[u] = (abort_at >= 0) && (c == (abort_at + 1) * dv - 1);
        end
        m_pos[u] = (m_pos[u] + sgn * taken) & 16'hFFFF;
        m_idx[u] = m_idx[u] + sgn * taken;
        if (hold) cmd_steps[u] = 16'd0;
    endtask

    initial begin
        int u, steps, ab;
        bit dir;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_dir[i] = 1'b0; cmd_steps[i] = 16'd0; abort[i] = 1'b0;
            m_idx[i] = 0; m_pos[i] = 0;
        end
        repeat (2) @(negedge clk1h);
        for (int i = 0; i < 2; i++) expect_outs(i, "reset", 1'b1, 1'b0, 1'b0, 16'd0, 4'b0101);
        rst = 1'b1;
        @(negedge clk1h);
        for (int i = 0; i < 2; i++) expect_outs(i, "post-reset", 1'b1, 1'b0, 1'b0, 16'd0, 4'b0101);

        // DIV=2 forward three steps, then DIV=1 reverse five steps wrapping below zero.
        run_move(0, 1'b1, 3, -1, 1'b0);
        chk("u0 pos after 3 fwd", {16'd0, pos[0]}, 32'd3);
        run_move(1, 1'b0, 5, -1, 1'b0);
        chk("u1 pos after 5 rev", {16'd0, pos[1]}, 32'h0000FFFB);

        // Zero-step command accepted while abort is high in IDLE.
        abort[1] = 1'b1;
        run_move(1, 1'b1, 0, -1, 1'b0);
        chk("u1 pos after zero move", {16'd0, pos[1]}, 32'h0000FFFB);

        // Abort after two steps, then a new command accepted right away.
        run_move(0, 1'b1, 10, 2, 1'b0);
        chk("u0 pos after abort", {16'd0, pos[0]}, 32'd5);
        run_move(0, 1'b0, 1, -1, 1'b0);

        // cmd_valid held high through a move; the follow-up acceptance is a zero move.
        run_move(1, 1'b1, 4, -1, 1'b1);
        run_move(1, 1'b0, 0, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            u     = i % 2;
            dir   = 1'($urandom);
            steps = $urandom_range(0, 9);
            ab    = (steps > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, steps - 1) : -1;
            run_move(u, dir, steps, ab, 1'($urandom_range(0, 3) == 0));
            if (cmd_valid[u]) run_move(u, 1'b0, 0, -1, 1'b0);
        end

        // Reset in the middle of a move.
        cmd_valid[1] = 1'b1; cmd_dir[1] = 1'b1; cmd_steps[1] = 16'd20;
        @(posedge clk1h);
        @(negedge clk1h);
        cmd_valid[1] = 1'b0;
        repeat (3) @(posedge clk1h);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            expect_outs(i, "mid-move reset", 1'b1, 1'b0, 1'b0, 16'd0, 4'b0101);
            m_idx[i] = 0; m_pos[i] = 0;
        end
        @(negedge clk1h);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk1h);
            expect_outs(1, "after reset release", 1'b1, 1'b0, 1'b0, 16'd0, 4'b0101);
        end

        run_move(1, 1'b1, 8, -1, 1'b0);
        chk("u1 pos after 8 fwd", {16'd0, pos[1]}, 32'd8);
`ifdef STEPMOTOR_HALF_STEP_EN
        chk("u1 half-step wrap phase", {28'd0, phase[1]}, 32'h5);
`else
        chk("u1 full-step wrap phase", {28'd0, phase[1]}, 32'h5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
